// File: rtl/aesl_deadlock_pkg.sv
// Shared definitions for the deadlock watchdog slice.
//   - Default parameter widths for the watchdog and its counters.
//   - Watchdog FSM state enum with a fixed 3-bit encoding (also exported on state_dbg).
package aesl_deadlock_pkg;

    localparam int unsigned DefaultNumAxis = 3;
    localparam int unsigned DefaultThreshW = 16;
    localparam int unsigned DefaultCntW    = 32;
    localparam int unsigned StateW         = 3;

    typedef enum logic [StateW-1:0] {
        StIdle    = 3'd0,
        StWatch   = 3'd1,
        StSuspect = 3'd2,
        StReport  = 3'd3,
        StHalt    = 3'd4
    } wd_state_e;

endpackage

// File: rtl/aesl_sat_counter.sv
// Saturating up-counter with synchronous clear and load.
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous active-high reset, zeroes the count
//   clear      - zero the count (highest priority)
//   load       - load load_value (beats inc)
//   load_value - value taken on load
//   inc        - increment by one, sticking at all-ones
//   count      - current count
module aesl_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             inc,
    output logic [Width-1:0] count
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + One;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/aesl_deadlock_watchdog.sv
// Deadlock watchdog: confirms a deadlock once the monitor tree reports "blocked" for a
// threshold number of consecutive cycles, then issues one valid/ready report carrying the
// persistently blocked, non-idle channels and a timestamp.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   enable              - arms the watchdog; low returns it to IDLE (except while reporting)
//   threshold           - consecutive blocked cycles to confirm (0 treated as 1)
//   monitor_block       - aggregated block flag
//   axis_block_sigs     - per-channel blocked flags
//   inst_idle_sigs      - per-channel idle flags
//   report_valid/ready  - report handshake
//   report_chan_mask    - channels blocked and non-idle throughout the suspect window
//   report_cycles       - timestamp of the confirm cycle
//   deadlock            - sticky confirmed flag, cleared only by reset
//   state_dbg           - current FSM state encoding
module aesl_deadlock_watchdog
    import aesl_deadlock_pkg::*;
#(
    parameter int unsigned NUM_AXIS = DefaultNumAxis,
    parameter int unsigned THRESH_W = DefaultThreshW,
    parameter int unsigned CNT_W    = DefaultCntW
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [THRESH_W-1:0] threshold,
    input  logic                monitor_block,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_AXIS-1:0] inst_idle_sigs,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [NUM_AXIS-1:0] report_chan_mask,
    output logic [CNT_W-1:0]    report_cycles,
    output logic                deadlock,
    output logic [2:0]          state_dbg
);

    localparam logic [THRESH_W-1:0] ThreshOne = {{(THRESH_W-1){1'b0}}, 1'b1};

    wd_state_e state_q, state_d;

    logic [NUM_AXIS-1:0] live_term;
    logic [NUM_AXIS-1:0] mask_q, mask_d;
    logic [NUM_AXIS-1:0] rpt_mask_q, rpt_mask_d;
    logic [CNT_W-1:0]    rpt_cycles_q, rpt_cycles_d;
    logic                deadlock_q, deadlock_d;

    logic [THRESH_W-1:0] thresh_eff;
    logic [THRESH_W-1:0] susp_count;
    logic [THRESH_W-1:0] susp_plus;
    logic                susp_clear, susp_load, susp_inc;
    logic [CNT_W-1:0]    ts_count;

    assign live_term  = axis_block_sigs & ~inst_idle_sigs;
    assign thresh_eff = (threshold == '0) ? ThreshOne : threshold;
    // Value the suspect counter takes this cycle if still blocked; confirm is judged on it so
    // the entry cycle counts as the first blocked cycle.
    assign susp_plus  = (&susp_count) ? susp_count : susp_count + ThreshOne;

    aesl_sat_counter #(
        .Width (THRESH_W)
    ) u_suspect_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (susp_clear),
        .load       (susp_load),
        .load_value (ThreshOne),
        .inc        (susp_inc),
        .count      (susp_count)
    );

    aesl_sat_counter #(
        .Width (CNT_W)
    ) u_timestamp_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (1'b0),
        .load       (1'b0),
        .load_value ({CNT_W{1'b0}}),
        .inc        (enable),
        .count      (ts_count)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        rpt_mask_d   = rpt_mask_q;
        rpt_cycles_d = rpt_cycles_q;
        deadlock_d   = deadlock_q;
        susp_clear   = 1'b0;
        susp_load    = 1'b0;
        susp_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                susp_clear = 1'b1;
                mask_d     = '0;
                if (enable) begin
                    state_d = StWatch;
                end
            end
            StWatch: begin
                if (!enable) begin
                    state_d    = StIdle;
                    susp_clear = 1'b1;
                    mask_d     = '0;
                end else if (monitor_block) begin
                    state_d   = StSuspect;
                    susp_load = 1'b1;
                    mask_d    = live_term;
                end
            end
            StSuspect: begin
                if (!enable) begin
                    state_d    = StIdle;
                    susp_clear = 1'b1;
                    mask_d     = '0;
                end else if (!monitor_block) begin
                    // A drop on the would-be confirm cycle also lands here: no report.
                    state_d    = StWatch;
                    susp_clear = 1'b1;
                    mask_d     = '0;
                end else begin
                    susp_inc = 1'b1;
                    mask_d   = mask_q & live_term;
                    if (susp_plus >= thresh_eff) begin
                        state_d      = StReport;
                        rpt_mask_d   = mask_q & live_term;
                        rpt_cycles_d = ts_count;
                        deadlock_d   = 1'b1;
                    end
                end
            end
            StReport: begin
                // Enable is ignored until the consumer takes the report.
                if (report_ready) begin
                    state_d = enable ? StHalt : StIdle;
                end
            end
            StHalt: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            rpt_mask_q   <= '0;
            rpt_cycles_q <= '0;
            deadlock_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            rpt_mask_q   <= rpt_mask_d;
            rpt_cycles_q <= rpt_cycles_d;
            deadlock_q   <= deadlock_d;
        end
    end

    assign report_valid     = (state_q == StReport);
    assign report_chan_mask = rpt_mask_q;
    assign report_cycles    = rpt_cycles_q;
    assign deadlock         = deadlock_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
module tb_aesl_deadlock_watchdog;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] threshold = '0;
    logic        monitor_block = 1'b0;
    logic [2:0]  axis_block_sigs = '0;
    logic [2:0]  inst_idle_sigs = '0;
    logic        report_valid;
    logic        report_ready = 1'b0;
    logic [2:0]  report_chan_mask;
    logic [31:0] report_cycles;
    logic        deadlock;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] SIdle = 3'd0, SWatch = 3'd1, SSusp = 3'd2, SRep = 3'd3, SHalt = 3'd4;

    aesl_deadlock_watchdog dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .threshold        (threshold),
        .monitor_block    (monitor_block),
        .axis_block_sigs  (axis_block_sigs),
        .inst_idle_sigs   (inst_idle_sigs),
        .report_valid     (report_valid),
        .report_ready     (report_ready),
        .report_chan_mask (report_chan_mask),
        .report_cycles    (report_cycles),
        .deadlock         (deadlock),
        .state_dbg        (state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] thr;
        logic        mb;
        logic [2:0]  axis;
        logic [2:0]  idle;
        logic        rdy;
        logic [2:0]  e_state;
        logic        e_valid;
        logic [2:0]  e_mask;
        logic [31:0] e_cyc;
        logic        e_dl;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic en, input logic [15:0] thr, input logic mb,
                       input logic [2:0] axis, input logic [2:0] idle, input logic rdy,
                       input logic [2:0] st, input logic v, input logic [2:0] m,
                       input logic [31:0] c, input logic dl);
        vec_t t;
        t = '{rst, en, thr, mb, axis, idle, rdy, st, v, m, c, dl};
        vq.push_back(t);
    endtask

    // Inputs are applied, then one rising edge, then outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        monitor_block = 1'b0;
        report_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int first_valid;
        int rises;
        logic prev_valid;

        // Table: rst en thr mb axis idle rdy | state valid mask cycles deadlock
        add(1, 0, 0, 0, 3'b000, 3'b000, 0,  SIdle,  0, 3'b000, 0, 0);
        add(0, 1, 4, 0, 3'b101, 3'b000, 0,  SWatch, 0, 3'b000, 0, 0);
        add(0, 1, 4, 1, 3'b101, 3'b000, 0,  SSusp,  0, 3'b000, 0, 0);
        add(0, 1, 4, 1, 3'b101, 3'b000, 0,  SSusp,  0, 3'b000, 0, 0);
        add(0, 1, 4, 1, 3'b101, 3'b000, 0,  SSusp,  0, 3'b000, 0, 0);
        add(0, 1, 4, 1, 3'b101, 3'b000, 0,  SRep,   1, 3'b101, 4, 1);
        add(0, 1, 4, 0, 3'b101, 3'b000, 1,  SHalt,  0, 3'b101, 4, 1);
        add(0, 0, 4, 0, 3'b101, 3'b000, 0,  SIdle,  0, 3'b101, 4, 1);
        add(0, 1, 2, 0, 3'b111, 3'b001, 0,  SWatch, 0, 3'b101, 4, 1);
        add(0, 1, 2, 1, 3'b111, 3'b001, 0,  SSusp,  0, 3'b101, 4, 1);
        add(0, 1, 2, 1, 3'b011, 3'b001, 0,  SRep,   1, 3'b010, 8, 1);
        add(0, 1, 2, 0, 3'b011, 3'b001, 1,  SHalt,  0, 3'b010, 8, 1);
        add(0, 0, 2, 0, 3'b000, 3'b000, 0,  SIdle,  0, 3'b010, 8, 1);
        add(0, 1, 4, 0, 3'b000, 3'b000, 0,  SWatch, 0, 3'b010, 8, 1);
        add(0, 1, 4, 1, 3'b111, 3'b000, 0,  SSusp,  0, 3'b010, 8, 1);
        add(0, 0, 4, 1, 3'b111, 3'b000, 0,  SIdle,  0, 3'b010, 8, 1);
        add(0, 1, 4, 0, 3'b111, 3'b000, 0,  SWatch, 0, 3'b010, 8, 1);
        add(0, 1, 4, 1, 3'b111, 3'b000, 0,  SSusp,  0, 3'b010, 8, 1);
        add(0, 1, 4, 1, 3'b111, 3'b000, 0,  SSusp,  0, 3'b010, 8, 1);
        add(0, 1, 4, 1, 3'b111, 3'b000, 0,  SSusp,  0, 3'b010, 8, 1);
        add(0, 1, 4, 0, 3'b111, 3'b000, 0,  SWatch, 0, 3'b010, 8, 1);

        for (int i = 0; i < vq.size(); i++) begin
            reset           = vq[i].rst;
            enable          = vq[i].en;
            threshold       = vq[i].thr;
            monitor_block   = vq[i].mb;
            axis_block_sigs = vq[i].axis;
            inst_idle_sigs  = vq[i].idle;
            report_ready    = vq[i].rdy;
            tick();
            chk($sformatf("vec%0d state", i), 32'(state_dbg), 32'(vq[i].e_state));
            chk($sformatf("vec%0d valid", i), 32'(report_valid), 32'(vq[i].e_valid));
            chk($sformatf("vec%0d mask", i), 32'(report_chan_mask), 32'(vq[i].e_mask));
            chk($sformatf("vec%0d cycles", i), report_cycles, vq[i].e_cyc);
            chk($sformatf("vec%0d deadlock", i), 32'(deadlock), 32'(vq[i].e_dl));
        end

        // Blocked 3, gap 1, blocked 4 with threshold 4: one report, after the second burst.
        do_reset();
        enable = 1'b1; threshold = 16'd4; axis_block_sigs = 3'b001; inst_idle_sigs = 3'b000;
        tick();
        first_valid = -1;
        rises = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            monitor_block = (i < 8) ? (i != 3) : 1'b0;
            tick();
            if (report_valid && !prev_valid) rises++;
            if (report_valid && first_valid < 0) first_valid = i;
            prev_valid = report_valid;
        end
        chk("burst first_valid", 32'(first_valid), 32'd7);
        chk("burst still_valid", 32'(report_valid), 32'd1);
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        chk("burst halt", 32'(state_dbg), 32'(SHalt));
        monitor_block = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (report_valid && !prev_valid) rises++;
            prev_valid = report_valid;
        end
        chk("burst one_report", 32'(rises), 32'd1);
        chk("burst halt_held", 32'(state_dbg), 32'(SHalt));

        // Threshold 0 acts as 1; payload held while ready stays low.
        do_reset();
        enable = 1'b1; threshold = 16'd0; axis_block_sigs = 3'b110; inst_idle_sigs = 3'b000;
        monitor_block = 1'b0;
        tick();
        monitor_block = 1'b1;
        tick();
        tick();
        monitor_block = 1'b0;
        chk("thr0 valid", 32'(report_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("thr0 hold%0d valid", i), 32'(report_valid), 32'd1);
            chk($sformatf("thr0 hold%0d mask", i), 32'(report_chan_mask), 32'(3'b110));
            chk($sformatf("thr0 hold%0d cycles", i), report_cycles, 32'd2);
        end
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        chk("thr0 halt", 32'(state_dbg), 32'(SHalt));
        chk("thr0 valid_low", 32'(report_valid), 32'd0);

        // Enable dropped while reporting: report held until taken, then IDLE.
        do_reset();
        enable = 1'b1; threshold = 16'd1; axis_block_sigs = 3'b111;
        tick();
        monitor_block = 1'b1;
        tick();
        tick();
        chk("endrop report", 32'(state_dbg), 32'(SRep));
        enable = 1'b0; monitor_block = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("endrop hold%0d valid", i), 32'(report_valid), 32'd1);
        end
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        chk("endrop idle", 32'(state_dbg), 32'(SIdle));
        chk("endrop deadlock", 32'(deadlock), 32'd1);

        // Reset during REPORT abandons it.
        enable = 1'b1;
        tick();
        monitor_block = 1'b1;
        tick();
        tick();
        chk("rstrep report", 32'(state_dbg), 32'(SRep));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        monitor_block = 1'b0;
        enable = 1'b0;
        chk("rstrep state", 32'(state_dbg), 32'(SIdle));
        chk("rstrep valid", 32'(report_valid), 32'd0);
        chk("rstrep mask", 32'(report_chan_mask), 32'd0);
        chk("rstrep cycles", report_cycles, 32'd0);
        chk("rstrep deadlock", 32'(deadlock), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
